// File: rtl/tile_dma_loader.sv
// Tile DMA loader: reads one TILE_W x TILE_H tile of a row-major image, one
// row request at a time, and streams the pixels into one half of a ping-pong tile buffer.
module tile_dma_loader #(
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080,
    parameter int TILE_W = 32,
    parameter int TILE_H = 32,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   dma_start,
    input  logic [$clog2(IMG_W/TILE_W)-1:0]        tile_x,
    input  logic [$clog2(IMG_H/TILE_H)-1:0]        tile_y,
    input  logic                                   buf_sel,
    input  logic [ADDR_W-1:0]                      frame_base,
    output logic                                   dma_done,
    output logic                                   busy,
    output logic                                   rd_req_valid,
    input  logic                                   rd_req_ready,
    output logic [ADDR_W-1:0]                      rd_req_addr,
    output logic [$clog2(TILE_W+1)-1:0]            rd_req_len,
    input  logic                                   rd_rsp_valid,
    output logic                                   rd_rsp_ready,
    input  logic [DATA_W-1:0]                      rd_rsp_data,
    output logic                                   buf_we,
    output logic [$clog2(2*TILE_W*TILE_H)-1:0]     buf_waddr,
    output logic [DATA_W-1:0]                      buf_wdata
);

    localparam int TS    = TILE_W * TILE_H;
    localparam int BA_W  = $clog2(2 * TS);
    localparam int RC_W  = $clog2(TILE_H + 1);
    localparam int LEN_W = $clog2(TILE_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic                start_prev_q;
    logic                buf_sel_q, buf_sel_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                req_valid_q, req_valid_d;
    logic [RC_W-1:0]     req_cnt_q, req_cnt_d;
    logic [BA_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic                start_edge;
    logic                req_fire;
    logic                beat_fire;
    logic [ADDR_W-1:0]   tile_origin;

    assign start_edge = dma_start && !start_prev_q && (state_q == IDLE);
    assign req_fire   = req_valid_q && rd_req_ready;
    assign beat_fire  = (state_q == RUN) && rd_rsp_valid;

    // Address of the tile's top-left pixel; arithmetic wraps at ADDR_W bits.
    assign tile_origin = frame_base
                       + ADDR_W'(tile_y) * ADDR_W'(TILE_H * IMG_W)
                       + ADDR_W'(tile_x) * ADDR_W'(TILE_W);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d     = state_q;
        buf_sel_d   = buf_sel_q;
        req_addr_d  = req_addr_q;
        req_valid_d = req_valid_q;
        req_cnt_d   = req_cnt_q;
        beat_cnt_d  = beat_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = RUN;
                    buf_sel_d   = buf_sel;
                    req_addr_d  = tile_origin;
                    req_valid_d = 1'b1;
                    req_cnt_d   = '0;
                    beat_cnt_d  = '0;
                end
            end
            RUN: begin
                // Request and response sides progress independently.
                if (req_fire) begin
                    req_cnt_d  = req_cnt_q + RC_W'(1);
                    req_addr_d = req_addr_q + ADDR_W'(IMG_W);
                    if (req_cnt_q == RC_W'(TILE_H - 1)) begin
                        req_valid_d = 1'b0;
                    end
                end
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + BA_W'(1);
                    if (beat_cnt_q == BA_W'(TS - 1)) begin
                        state_d     = DONE;
                        req_valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                req_cnt_d  = '0;
                beat_cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b1;
            buf_sel_q    <= 1'b0;
            req_addr_q   <= '0;
            req_valid_q  <= 1'b0;
            req_cnt_q    <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= dma_start;
            buf_sel_q    <= buf_sel_d;
            req_addr_q   <= req_addr_d;
            req_valid_q  <= req_valid_d;
            req_cnt_q    <= req_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign dma_done     = (state_q == DONE);
    assign rd_rsp_ready = (state_q == RUN);
    assign rd_req_valid = req_valid_q;
    assign rd_req_addr  = req_addr_q;
    assign rd_req_len   = LEN_W'(TILE_W);
    assign buf_we       = beat_fire;
    assign buf_waddr    = buf_sel_q ? (BA_W'(TS) + beat_cnt_q) : beat_cnt_q;
    assign buf_wdata    = rd_rsp_data;

endmodule

// File: tb/tb_tile_dma_loader.sv
// Self-checking bench for tile_dma_loader: a queue-based model of expected requests
// and buffer writes, checked every cycle, plus literal expectations per scenario.
module tb_tile_dma_loader;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int TILE_W = 4;
    localparam int TILE_H = 2;
    localparam int TS     = TILE_W * TILE_H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_start;
    logic [0:0]  tile_x;
    logic [0:0]  tile_y;
    logic        buf_sel;
    logic [31:0] frame_base;
    logic        dma_done;
    logic        busy;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [31:0] rd_req_addr;
    logic [2:0]  rd_req_len;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [7:0]  rd_rsp_data;
    logic        buf_we;
    logic [3:0]  buf_waddr;
    logic [7:0]  buf_wdata;

    tile_dma_loader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .TILE_W(TILE_W), .TILE_H(TILE_H),
        .DATA_W(8), .ADDR_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dma_start(dma_start),
        .tile_x(tile_x), .tile_y(tile_y), .buf_sel(buf_sel), .frame_base(frame_base),
        .dma_done(dma_done), .busy(busy),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata)
    );

    always #5 clk = ~clk;

    // Counters and model state owned by the compare process.
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] exp_req[$];
    int          exp_wa[$];
    bit          m_active = 0;
    bit          m_done = 0;
    bit          m_prev_start = 1;
    logic [31:0] obs_req[$];
    int          obs_wa[$];
    int          obs_wd[$];
    int          obs_done = 0;
    int          obs_stall = 0;
    int          last_beat_cyc = 0;
    int          done_cyc = 0;
    int          pin_ack = 0;

    // Owned by the stimulus process.
    int          pin_req = 0;
    int          pin_kind = 0;
    bit          timeout_seen = 0;
    logic [63:0] rst_snap = '0;
    int          rbeat = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_pins(input int kind);
        check("no_timeout", 64'(timeout_seen), 64'(0));
        case (kind)
            1: begin
                check("p1_req_count", 64'(obs_req.size()), 64'(2));
                check("p1_req0", 64'(obs_req[0]), 64'h114);
                check("p1_req1", 64'(obs_req[1]), 64'h11C);
                check("p1_write_count", 64'(obs_wa.size()), 64'(8));
                for (int k = 0; k < 8; k++) begin
                    check("p1_waddr", 64'(obs_wa[k]), 64'(8 + k));
                    check("p1_wdata", 64'(obs_wd[k]), 64'(8'hA0 + k));
                end
                check("p1_done_count", 64'(obs_done), 64'(1));
                check("p1_done_latency", 64'(done_cyc - last_beat_cyc), 64'(1));
            end
            2: begin
                check("p2_req_count", 64'(obs_req.size()), 64'(2));
                check("p2_req0", 64'(obs_req[0]), 64'h114);
                check("p2_stall_cycles", 64'(obs_stall), 64'(3));
                check("p2_write_count", 64'(obs_wa.size()), 64'(8));
                check("p2_done_count", 64'(obs_done), 64'(1));
            end
            3: begin
                check("p3_done_count", 64'(obs_done), 64'(1));
                check("p3_write_count", 64'(obs_wa.size()), 64'(8));
                check("p3_busy_idle", 64'(busy), 64'(0));
            end
            4: begin
                check("p4_req0", 64'(obs_req[0]), 64'h100);
                check("p4_req1", 64'(obs_req[1]), 64'h108);
                check("p4_waddr_first", 64'(obs_wa[0]), 64'(0));
                check("p4_waddr_last", 64'(obs_wa[7]), 64'(7));
                check("p4_write_count", 64'(obs_wa.size()), 64'(8));
            end
            5: begin
                check("p5_write_count", 64'(obs_wa.size()), 64'(3));
                check("p5_done_count", 64'(obs_done), 64'(0));
                check("p5_reset_outputs", rst_snap, 64'(0));
                check("p5_busy_after_release", 64'(busy), 64'(0));
            end
            6: begin
                check("p6_req0", 64'(obs_req[0]), 64'h104);
                check("p6_req1", 64'(obs_req[1]), 64'h10C);
                check("p6_write_count", 64'(obs_wa.size()), 64'(8));
                check("p6_done_count", 64'(obs_done), 64'(1));
            end
            7: begin
                check("p7_write_count", 64'(obs_wa.size()), 64'(8));
                check("p7_waddr_first", 64'(obs_wa[0]), 64'(8));
                check("p7_done_count", 64'(obs_done), 64'(1));
            end
            default: check("pin_kind_known", 64'(kind), 64'(0));
        endcase
        obs_req.delete();
        obs_wa.delete();
        obs_wd.delete();
        obs_done  = 0;
        obs_stall = 0;
    endtask

    // Compare process: outputs are sampled mid-cycle, inputs are stable then.
    always @(negedge clk) begin
        bit e_valid;
        bit e_we;
        cyc++;
        if (!rst_n) begin
            check("rst_flags", 64'({dma_done, busy, rd_req_valid, rd_rsp_ready, buf_we}), 64'(0));
            check("rst_addrs", 64'({rd_req_addr, buf_waddr}), 64'(0));
            exp_req.delete();
            exp_wa.delete();
            m_active     = 0;
            m_done       = 0;
            m_prev_start = 1;
        end else begin
            e_valid = m_active && (exp_req.size() > 0);
            e_we    = m_active && rd_rsp_valid;
            check("busy", 64'(busy), 64'(m_active || m_done));
            check("dma_done", 64'(dma_done), 64'(m_done));
            check("rsp_ready", 64'(rd_rsp_ready), 64'(m_active));
            check("req_valid", 64'(rd_req_valid), 64'(e_valid));
            if (e_valid && rd_req_valid) begin
                check("req_addr", 64'(rd_req_addr), 64'(exp_req[0]));
                check("req_len", 64'(rd_req_len), 64'(TILE_W));
            end
            check("buf_we", 64'(buf_we), 64'(e_we));
            if (e_we && buf_we) begin
                check("buf_waddr", 64'(buf_waddr), 64'(exp_wa[0]));
                check("buf_wdata", 64'(buf_wdata), 64'(rd_rsp_data));
            end

            if (rd_req_valid && rd_req_ready) obs_req.push_back(rd_req_addr);
            if (rd_req_valid && !rd_req_ready && rd_req_addr == 32'h114) obs_stall++;
            if (buf_we) begin
                obs_wa.push_back(int'(buf_waddr));
                obs_wd.push_back(int'(buf_wdata));
                last_beat_cyc = cyc;
            end
            if (dma_done) begin
                obs_done++;
                done_cyc = cyc;
            end

            // Advance the model to what the next rising edge must produce.
            if (m_done) begin
                m_done = 0;
            end else if (m_active) begin
                if (e_valid && rd_req_ready) void'(exp_req.pop_front());
                if (e_we) begin
                    void'(exp_wa.pop_front());
                    if (exp_wa.size() == 0) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end else if (dma_start && !m_prev_start) begin
                for (int r = 0; r < TILE_H; r++)
                    exp_req.push_back(32'(frame_base + (32'(tile_y) * TILE_H + r) * IMG_W
                                          + 32'(tile_x) * TILE_W));
                for (int k = 0; k < TS; k++)
                    exp_wa.push_back(int'(buf_sel) * TS + k);
                m_active = 1;
            end
            m_prev_start = dma_start;

            if (pin_ack != pin_req) begin
                do_pins(pin_kind);
                pin_ack = pin_req;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pin(input int kind);
        pin_kind = kind;
        pin_req++;
        for (int i = 0; i < 10 && pin_ack != pin_req; i++) step();
        if (pin_ack != pin_req) begin
            $display("FAIL pin_handshake: kind %0d not serviced", kind);
            $fatal(1, "compare process stalled");
        end
    endtask

    task automatic run_job(input logic tx, input logic ty, input logic bs, input int stall,
                           input int bstart, input bit gap, input bit sticky,
                           input logic [7:0] dbase);
        int  beat;
        bit  got_done;
        beat     = 0;
        got_done = 0;
        dma_start = 1'b0;
        step();
        tile_x = tx; tile_y = ty; buf_sel = bs; frame_base = 32'h100;
        dma_start = 1'b1;
        step();
        if (!sticky) dma_start = 1'b0;
        // Scramble job inputs to show they were captured at the start edge.
        tile_x = ~tx; tile_y = ~ty; buf_sel = ~bs; frame_base = 32'h0F00;
        for (int c = 0; c < 60 && !got_done; c++) begin
            rd_req_ready = (c >= stall);
            rd_rsp_valid = (c >= bstart) && (beat < TS) && !(gap && (c % 2 == 1));
            rd_rsp_data  = dbase + 8'(beat);
            @(negedge clk);
            if (rd_rsp_valid && rd_rsp_ready) beat++;
            if (dma_done) got_done = 1;
            step();
            if (sticky && got_done) dma_start = 1'b0;
        end
        if (!got_done) timeout_seen = 1;
        rd_rsp_valid = 1'b0;
        rd_req_ready = 1'b1;
        dma_start    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dma_start = 1'b0; tile_x = '0; tile_y = '0; buf_sel = 1'b0;
        frame_base = 32'h100; rd_req_ready = 1'b1; rd_rsp_valid = 1'b0; rd_rsp_data = '0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Basic pong tile (1,1), no backpressure.
        run_job(1'b1, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 8'hA0);
        idle(3); pin(1);

        // Request backpressure for 3 cycles; early beats and same-cycle issue/beat.
        run_job(1'b1, 1'b1, 1'b1, 3, 1, 1'b1, 1'b0, 8'h50);
        idle(3); pin(2);

        // dma_start held high until one cycle after dma_done.
        run_job(1'b0, 1'b1, 1'b0, 0, 2, 1'b0, 1'b1, 8'h30);
        idle(3); pin(3);

        // Ping tile at the image origin.
        run_job(1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 8'h10);
        idle(3); pin(4);

        // Reset after 3 beats, with dma_start still high across release.
        dma_start = 1'b0;
        step();
        tile_x = 1'b0; tile_y = 1'b0; buf_sel = 1'b1; frame_base = 32'h100;
        dma_start = 1'b1;
        step();
        rbeat = 0;
        for (int c = 0; c < 40 && rbeat < 3; c++) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = 8'h20 + 8'(rbeat);
            @(negedge clk);
            if (rd_rsp_valid && rd_rsp_ready) rbeat++;
            step();
        end
        rst_n = 1'b0;
        #1;
        rst_snap = 64'({dma_done, busy, rd_req_valid, rd_rsp_ready, buf_we, rd_req_addr, buf_waddr});
        idle(2);
        rst_n = 1'b1;
        rd_rsp_valid = 1'b0;
        idle(3);
        pin(5);

        // Fresh edge after reset runs a clean job.
        run_job(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 8'h60);
        idle(3); pin(6);

        // Stray response data while idle, then a normal job.
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = 8'hEE;
        idle(4);
        run_job(1'b1, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 8'h70);
        idle(3); pin(7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
